// File: rtl/fib_host_pkg.sv
// Shared types and defaults for the fib kernel request initiator.
package fib_host_pkg;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_TIMEOUT = 4096;
    localparam int DEF_RST_CYC = 2;

    // Sequencer states, 3-bit encoding.
    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_IDLE    = 3'd1,
        ST_REQ     = 3'd2,
        ST_WAIT    = 3'd3,
        ST_RECOVER = 3'd4,
        ST_RESP    = 3'd5
    } state_t;

    // Bits needed to count 0..v-1; never less than one bit.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/fib_host_watchdog.sv
// Clearable up-counter that flags when it sits on its last count (TIMEOUT-1).
module fib_host_watchdog
    import fib_host_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CW      = clog2_min1(TIMEOUT)
) (
    input  logic i_w_clk,
    input  logic i_w_res_n,
    input  logic i_w_clr,
    input  logic i_w_en,
    output logic o_w_expire
);

    logic [CW-1:0] r_cnt;

    // Count enabled cycles; clear wins over enable.
    always_ff @(posedge i_w_clk or negedge i_w_res_n) begin
        if (!i_w_res_n) begin
            r_cnt <= '0;
        end else if (i_w_clr) begin
            r_cnt <= '0;
        end else if (i_w_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_w_expire = (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/fib_host_seq.sv
// Drives one fib kernel job at a time: accept argument, pulse req, wait for
// fin (or time out and reset the kernel), then return the result.
//
// Handshakes: a word moves on an edge where valid and ready are both high.
// The host holds o_r_m_valid/o_r_m_o/o_r_m_err stable until i_w_m_ready;
// o_r_s_ready and o_r_m_valid are never high together.
module fib_host_seq
    import fib_host_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int RST_CYC = DEF_RST_CYC
) (
    input  logic                    i_w_clk,
    input  logic                    i_w_res_n,
    input  logic                    i_w_s_valid,
    output logic                    o_r_s_ready,
    input  logic signed [WIDTH-1:0] i_w_s_n,
    output logic                    o_r_m_valid,
    input  logic                    i_w_m_ready,
    output logic signed [WIDTH-1:0] o_r_m_o,
    output logic                    o_r_m_err,
    output logic                    o_r_kern_res_p,
    output logic                    o_r_kern_ce_p,
    output logic                    o_r_kern_req_p,
    output logic signed [WIDTH-1:0] o_r_kern_n,
    input  logic                    i_w_kern_fin_p,
    input  logic signed [WIDTH-1:0] i_w_kern_o,
    output state_t                  o_r_dbg_state
);

    localparam int RW = clog2_min1(RST_CYC);

    state_t                  r_state;
    logic [RW-1:0]           r_rec_cnt;

    state_t                  w_state_nxt;
    logic [RW-1:0]           w_rec_cnt_nxt;
    logic                    w_s_ready_nxt;
    logic                    w_m_valid_nxt;
    logic signed [WIDTH-1:0] w_m_o_nxt;
    logic                    w_m_err_nxt;
    logic                    w_kern_res_nxt;
    logic                    w_kern_ce_nxt;
    logic                    w_kern_req_nxt;
    logic signed [WIDTH-1:0] w_kern_n_nxt;
    logic                    w_wd_clr;
    logic                    w_wd_en;
    logic                    w_wd_expire;

    fib_host_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .i_w_clk    (i_w_clk),
        .i_w_res_n  (i_w_res_n),
        .i_w_clr    (w_wd_clr),
        .i_w_en     (w_wd_en),
        .o_w_expire (w_wd_expire)
    );

    // State and every output are registers; reset holds the kernel in reset.
    always_ff @(posedge i_w_clk or negedge i_w_res_n) begin
        if (!i_w_res_n) begin
            r_state        <= ST_INIT;
            r_rec_cnt      <= '0;
            o_r_s_ready    <= 1'b0;
            o_r_m_valid    <= 1'b0;
            o_r_m_o        <= '0;
            o_r_m_err      <= 1'b0;
            o_r_kern_res_p <= 1'b1;
            o_r_kern_ce_p  <= 1'b0;
            o_r_kern_req_p <= 1'b0;
            o_r_kern_n     <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_rec_cnt      <= w_rec_cnt_nxt;
            o_r_s_ready    <= w_s_ready_nxt;
            o_r_m_valid    <= w_m_valid_nxt;
            o_r_m_o        <= w_m_o_nxt;
            o_r_m_err      <= w_m_err_nxt;
            o_r_kern_res_p <= w_kern_res_nxt;
            o_r_kern_ce_p  <= w_kern_ce_nxt;
            o_r_kern_req_p <= w_kern_req_nxt;
            o_r_kern_n     <= w_kern_n_nxt;
        end
    end

    // Next-state and next-output decode; everything holds unless a state acts.
    always_comb begin
        w_state_nxt    = r_state;
        w_rec_cnt_nxt  = r_rec_cnt;
        w_s_ready_nxt  = o_r_s_ready;
        w_m_valid_nxt  = o_r_m_valid;
        w_m_o_nxt      = o_r_m_o;
        w_m_err_nxt    = o_r_m_err;
        w_kern_res_nxt = o_r_kern_res_p;
        w_kern_ce_nxt  = o_r_kern_ce_p;
        w_kern_req_nxt = o_r_kern_req_p;
        w_kern_n_nxt   = o_r_kern_n;
        w_wd_clr       = 1'b0;
        w_wd_en        = 1'b0;

        case (r_state)
            ST_INIT: begin
                w_kern_res_nxt = 1'b0;
                w_kern_ce_nxt  = 1'b1;
                w_s_ready_nxt  = 1'b1;
                w_state_nxt    = ST_IDLE;
            end
            ST_IDLE: begin
                if (i_w_s_valid && o_r_s_ready) begin
                    w_kern_n_nxt   = i_w_s_n;
                    w_s_ready_nxt  = 1'b0;
                    w_kern_req_nxt = 1'b1;
                    w_state_nxt    = ST_REQ;
                end
            end
            ST_REQ: begin
                // Counter reads 0 in the first WAIT cycle.
                w_kern_req_nxt = 1'b0;
                w_wd_clr       = 1'b1;
                w_state_nxt    = ST_WAIT;
            end
            ST_WAIT: begin
                w_wd_en = 1'b1;
                if (i_w_kern_fin_p) begin
                    // fin beats a timeout landing on the same edge.
                    w_m_o_nxt     = i_w_kern_o;
                    w_m_err_nxt   = 1'b0;
                    w_m_valid_nxt = 1'b1;
                    w_state_nxt   = ST_RESP;
                end else if (w_wd_expire) begin
                    w_m_o_nxt      = '0;
                    w_m_err_nxt    = 1'b1;
                    w_kern_res_nxt = 1'b1;
                    w_rec_cnt_nxt  = '0;
                    w_state_nxt    = ST_RECOVER;
                end
            end
            ST_RECOVER: begin
                if (r_rec_cnt == RW'(RST_CYC - 1)) begin
                    w_kern_res_nxt = 1'b0;
                    w_m_valid_nxt  = 1'b1;
                    w_state_nxt    = ST_RESP;
                end else begin
                    w_rec_cnt_nxt = r_rec_cnt + 1'b1;
                end
            end
            ST_RESP: begin
                if (i_w_m_ready) begin
                    w_m_valid_nxt = 1'b0;
                    w_s_ready_nxt = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    assign o_r_dbg_state = r_state;

endmodule

// File: tb/tb_fib_host_seq.sv
// Directed bench for fib_host_seq; the kernel side is played by tasks here.
module tb_fib_host_seq;
    import fib_host_pkg::*;

    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 16;
    localparam int RST_CYC = 2;

    logic                    i_w_clk;
    logic                    i_w_res_n;
    logic                    i_w_s_valid;
    logic                    o_r_s_ready;
    logic signed [WIDTH-1:0] i_w_s_n;
    logic                    o_r_m_valid;
    logic                    i_w_m_ready;
    logic signed [WIDTH-1:0] o_r_m_o;
    logic                    o_r_m_err;
    logic                    o_r_kern_res_p;
    logic                    o_r_kern_ce_p;
    logic                    o_r_kern_req_p;
    logic signed [WIDTH-1:0] o_r_kern_n;
    logic                    i_w_kern_fin_p;
    logic signed [WIDTH-1:0] i_w_kern_o;
    state_t                  o_r_dbg_state;

    int checks   = 0;
    int failures = 0;

    fib_host_seq #(
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT),
        .RST_CYC (RST_CYC)
    ) dut (
        .i_w_clk        (i_w_clk),
        .i_w_res_n      (i_w_res_n),
        .i_w_s_valid    (i_w_s_valid),
        .o_r_s_ready    (o_r_s_ready),
        .i_w_s_n        (i_w_s_n),
        .o_r_m_valid    (o_r_m_valid),
        .i_w_m_ready    (i_w_m_ready),
        .o_r_m_o        (o_r_m_o),
        .o_r_m_err      (o_r_m_err),
        .o_r_kern_res_p (o_r_kern_res_p),
        .o_r_kern_ce_p  (o_r_kern_ce_p),
        .o_r_kern_req_p (o_r_kern_req_p),
        .o_r_kern_n     (o_r_kern_n),
        .i_w_kern_fin_p (i_w_kern_fin_p),
        .i_w_kern_o     (i_w_kern_o),
        .o_r_dbg_state  (o_r_dbg_state)
    );

    // Clock: 10 ns period.
    initial begin
        i_w_clk = 1'b0;
        forever #5 i_w_clk = ~i_w_clk;
    end

    // Kernel behaviour: n<=0 gives 0, else fib(n) with 32-bit wrap.
    function automatic logic signed [31:0] fib_k(input logic signed [31:0] n);
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] t;
        a = 32'd0;
        b = 32'd1;
        if (n <= 0) return 32'sd0;
        for (int i = 1; i < n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return b;
    endfunction

    task automatic tick();
        @(negedge i_w_clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // Present n until accepted; returns on the negedge after the accepting edge.
    task automatic send_arg(input string tag, input logic signed [31:0] n);
        bit ok;
        ok = 1'b0;
        i_w_s_valid = 1'b1;
        i_w_s_n     = n;
        for (int i = 0; i < 20; i++) begin
            if (o_r_s_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        tick();
        i_w_s_valid = 1'b0;
        i_w_s_n     = 32'sh5A5A5A5A;
        check({tag, "_accept"}, 32'(ok), 32'd1);
    endtask

    // One job against the kernel model, fin after lat cycles of WAIT/REQ.
    task automatic run_job(input string tag, input logic signed [31:0] n,
                           input logic signed [31:0] exp, input int lat, input bit release_m);
        int req_hi;
        int rdy_hi;
        send_arg(tag, n);
        check({tag, "_req"}, 32'(o_r_kern_req_p), 32'd1);
        check({tag, "_kern_n"}, o_r_kern_n, n);
        check({tag, "_busy"}, 32'(o_r_s_ready), 32'd0);
        req_hi = 0;
        rdy_hi = 0;
        for (int i = 0; i < lat; i++) begin
            tick();
            req_hi += int'(o_r_kern_req_p);
            rdy_hi += int'(o_r_s_ready);
        end
        check({tag, "_req_width"}, 32'(req_hi), 32'd0);
        i_w_kern_fin_p = 1'b1;
        i_w_kern_o     = fib_k(n);
        tick();
        i_w_kern_fin_p = 1'b0;
        i_w_kern_o     = 32'sd0;
        rdy_hi += int'(o_r_s_ready);
        check({tag, "_ready_low"}, 32'(rdy_hi), 32'd0);
        check({tag, "_m_valid"}, 32'(o_r_m_valid), 32'd1);
        check({tag, "_m_o"}, o_r_m_o, exp);
        check({tag, "_m_err"}, 32'(o_r_m_err), 32'd0);
        check({tag, "_kern_n_hold"}, o_r_kern_n, n);
        if (release_m) begin
            tick();
            check({tag, "_m_valid_drop"}, 32'(o_r_m_valid), 32'd0);
            check({tag, "_ready_back"}, 32'(o_r_s_ready), 32'd1);
        end
    endtask

    initial begin
        int bad;
        int res_hi;
        int mv_idx;
        int mv_cnt;

        i_w_res_n      = 1'b0;
        i_w_s_valid    = 1'b0;
        i_w_s_n        = 32'sd0;
        i_w_m_ready    = 1'b0;
        i_w_kern_fin_p = 1'b0;
        i_w_kern_o     = 32'sd0;

        // Reset values.
        repeat (3) tick();
        check("rst_kern_res", 32'(o_r_kern_res_p), 32'd1);
        check("rst_ce", 32'(o_r_kern_ce_p), 32'd0);
        check("rst_req", 32'(o_r_kern_req_p), 32'd0);
        check("rst_s_ready", 32'(o_r_s_ready), 32'd0);
        check("rst_m_valid", 32'(o_r_m_valid), 32'd0);
        check("rst_m_o", o_r_m_o, 32'd0);
        check("rst_m_err", 32'(o_r_m_err), 32'd0);
        check("rst_kern_n", o_r_kern_n, 32'd0);
        check("rst_state", 32'(o_r_dbg_state), 32'(ST_INIT));

        // One cycle after release the kernel runs and the host is idle.
        i_w_res_n = 1'b1;
        tick();
        check("init_kern_res", 32'(o_r_kern_res_p), 32'd0);
        check("init_ce", 32'(o_r_kern_ce_p), 32'd1);
        check("init_s_ready", 32'(o_r_s_ready), 32'd1);
        check("init_state", 32'(o_r_dbg_state), 32'(ST_IDLE));

        // Single job, result consumed immediately.
        i_w_m_ready = 1'b1;
        run_job("n10", 32'sd10, 32'sd55, 3, 1'b1);

        // Back-to-back jobs including zero, negative and wrap boundary.
        run_job("n1", 32'sd1, 32'sd1, 4, 1'b1);
        run_job("n0", 32'sd0, 32'sd0, 2, 1'b1);
        run_job("nm5", -32'sd5, 32'sd0, 5, 1'b1);
        run_job("n46", 32'sd46, 32'sd1836311903, 6, 1'b1);

        // Backpressure: result must sit unchanged for 50 cycles.
        i_w_m_ready = 1'b0;
        run_job("bp", 32'sd20, 32'sd6765, 5, 1'b0);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (o_r_m_valid !== 1'b1 || o_r_m_o !== 32'sd6765 || o_r_s_ready !== 1'b0) bad++;
        end
        check("bp_stable", 32'(bad), 32'd0);
        i_w_m_ready = 1'b1;
        tick();
        check("bp_release_valid", 32'(o_r_m_valid), 32'd0);
        check("bp_release_ready", 32'(o_r_s_ready), 32'd1);

        // Timeout: kernel never finishes and drives junk on its result.
        i_w_kern_o = 32'sd4660;
        send_arg("tmo", 32'sd7);
        res_hi = 0;
        mv_idx = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (o_r_kern_res_p) res_hi++;
            if (o_r_m_valid) begin
                mv_idx = i;
                break;
            end
        end
        // Index 0 is the req cycle; count from the first cycle after the pulse.
        check("tmo_latency", 32'(mv_idx - 1), 32'(TIMEOUT + RST_CYC));
        check("tmo_kern_res_cycles", 32'(res_hi), 32'(RST_CYC));
        check("tmo_m_err", 32'(o_r_m_err), 32'd1);
        check("tmo_m_o", o_r_m_o, 32'd0);
        check("tmo_kern_res_off", 32'(o_r_kern_res_p), 32'd0);
        tick();
        check("tmo_m_valid_drop", 32'(o_r_m_valid), 32'd0);
        i_w_kern_o = 32'sd0;

        // Kernel still usable after recovery.
        run_job("after_tmo", 32'sd5, 32'sd5, 3, 1'b1);

        // fin on the very cycle the counter reaches TIMEOUT-1.
        send_arg("edge", 32'sd9);
        res_hi = 0;
        mv_cnt = 0;
        for (int i = 1; i <= TIMEOUT; i++) begin
            tick();
            res_hi += int'(o_r_kern_res_p);
            mv_cnt += int'(o_r_m_valid);
        end
        check("edge_no_early", 32'(res_hi + mv_cnt), 32'd0);
        i_w_kern_fin_p = 1'b1;
        i_w_kern_o     = 32'sd12345;
        tick();
        i_w_kern_fin_p = 1'b0;
        i_w_kern_o     = 32'sd0;
        check("edge_m_valid", 32'(o_r_m_valid), 32'd1);
        check("edge_m_o", o_r_m_o, 32'sd12345);
        check("edge_m_err", 32'(o_r_m_err), 32'd0);
        check("edge_no_recover", 32'(o_r_kern_res_p), 32'd0);
        tick();
        check("edge_drop", 32'(o_r_m_valid), 32'd0);
        check("edge_res_still_off", 32'(o_r_kern_res_p), 32'd0);

        // Stray fin while idle changes nothing.
        i_w_kern_fin_p = 1'b1;
        i_w_kern_o     = 32'sd999;
        tick();
        i_w_kern_fin_p = 1'b0;
        i_w_kern_o     = 32'sd0;
        check("stray_m_valid", 32'(o_r_m_valid), 32'd0);
        check("stray_s_ready", 32'(o_r_s_ready), 32'd1);
        check("stray_m_o", o_r_m_o, 32'sd12345);
        check("stray_state", 32'(o_r_dbg_state), 32'(ST_IDLE));

        // Reset mid-job: kernel reset asserts immediately, job is dropped.
        send_arg("midrst", 32'sd10);
        tick();
        i_w_res_n = 1'b0;
        #1;
        check("midrst_kern_res", 32'(o_r_kern_res_p), 32'd1);
        check("midrst_m_valid", 32'(o_r_m_valid), 32'd0);
        check("midrst_kern_n", o_r_kern_n, 32'd0);
        tick();
        i_w_res_n = 1'b1;
        tick();
        check("midrst_ready", 32'(o_r_s_ready), 32'd1);
        check("midrst_m_valid_after", 32'(o_r_m_valid), 32'd0);
        run_job("after_rst", 32'sd2, 32'sd1, 2, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fib_host_seq.md
# fib_host_seq

Request initiator for the generated `fib` compute kernel. It accepts argument words on a valid/ready input stream and drives the kernel's req/fin/ce handshake, one job at a time. It captures the kernel result on `fin` and returns it with an error flag on a valid/ready output stream. A watchdog recovers the kernel if `fin` never arrives. The block sits between the message-pack RPC decoder/encoder and the kernel.

## Interface
Parameters:
- `WIDTH`, 32: argument/result width; must match kernel `i_w_n`/`o_r_o`.
- `TIMEOUT`, 4096: maximum WAIT cycles before recovery; must be ≥ 2.
- `RST_CYC`, 2: cycles `o_r_kern_res_p` is held high during recovery; must be ≥ 1.

Ports:
- `i_w_clk` in 1: clock.
- `i_w_res_n` in 1: reset, asynchronous, active-low.
- `i_w_s_valid` in 1: argument valid.
- `o_r_s_ready` out 1: argument ready.
- `i_w_s_n` in WIDTH: argument n, signed.
- `o_r_m_valid` out 1: result valid.
- `i_w_m_ready` in 1: result ready.
- `o_r_m_o` out WIDTH: result, signed.
- `o_r_m_err` out 1: 1 = timeout, result forced to 0.
- `o_r_kern_res_p` out 1: kernel reset, synchronous, active-high.
- `o_r_kern_ce_p` out 1: kernel clock enable.
- `o_r_kern_req_p` out 1: kernel request pulse.
- `o_r_kern_n` out WIDTH: kernel argument.
- `i_w_kern_fin_p` in 1: kernel finish pulse.
- `i_w_kern_o` in WIDTH: kernel result.

## Operation
States: INIT, IDLE, REQ, WAIT, RECOVER, RESP.
- Reset (`i_w_res_n`=0), asynchronous:
  - state=INIT; `o_r_kern_res_p`=1.
  - all other outputs 0, including `o_r_kern_n` and the counter.
- INIT: one cycle. Set `kern_res`=0, `ce`=1, then IDLE. `ce` stays 1 until the next reset.
- IDLE: `s_ready`=1. On `s_valid&&s_ready`: latch `i_w_s_n` into `o_r_kern_n`, drop `s_ready`, go REQ.
- REQ: `o_r_kern_req_p`=1 for exactly one cycle. Clear the counter, go WAIT.
- WAIT: `req`=0; counter increments each cycle.
  - `fin`=1: `m_o`←`i_w_kern_o`, `m_err`←0, go RESP. `fin` has priority over timeout in the same cycle.
  - counter==TIMEOUT-1 and no `fin`: `m_o`←0, `m_err`←1, `kern_res`=1, go RECOVER.
- RECOVER: hold `kern_res`=1 for RST_CYC cycles total, then deassert it and go RESP.
- RESP: `m_valid`=1; `m_o`/`m_err` stable while `m_ready`=0. On `m_ready`: `m_valid`=0, go IDLE.
- `fin` outside WAIT is ignored; no state or output change.
- `o_r_kern_n` is held from the latch until the next accept.
- Arithmetic and comparisons are done by the kernel. This block only transports words, bit-exact, signed, no truncation.
- Kernel semantics relied on:
  - n≤0 → 0; otherwise fib(n), with fib(1)=fib(2)=1.
  - 32-bit wrap beyond fib(46) is passed through unchanged.

## Timing
- Accept→`req` high: next cycle. `req` width: 1 cycle.
- `fin` sampled high at edge k → `m_valid` high after edge k. `i_w_kern_o` is captured at the same edge; the kernel clears its output the following cycle.
- RESP→IDLE on the `m_ready` edge. The next accept is possible the cycle after, so throughput ≤ 1 job per (kernel latency + 4) cycles.
- Timeout path: `m_valid` rises TIMEOUT+RST_CYC cycles after `req`.
- Reset mid-job: job discarded, no `m_valid` emitted, kernel reset asserted immediately (asynchronous).
- `s_ready` and `m_valid` are never high together.

## Structure
- Package `fib_host_pkg`:
  - state enum (3-bit encoding);
  - `ST_INIT`..`ST_RESP` constants;
  - default `WIDTH`/`TIMEOUT`;
  - counter width `clog2(TIMEOUT)`.
- Sub-module `fib_host_watchdog`: clearable up-counter with `expire` output; instantiated once.
- Everything else is a single registered FSM; all outputs are registers.

## Test plan
- Reset then idle, bench with real `fib`:
  - during reset: all outputs 0 except `kern_res`=1;
  - one cycle after release: `kern_res`=0, `ce`=1, `s_ready`=1.
- Send n=10, `m_ready`=1 → `m_o`=55, `m_err`=0, single `req` pulse, `m_valid` one cycle.
- Back-to-back n=1, 0, -5, 46 → results 1, 0, 0, 1836311903 in order. `s_ready` low while each job is outstanding.
- Backpressure: n=20 with `m_ready`=0 for 50 cycles → `m_o`=6765 stable with `m_valid` held; cleared on the cycle after `m_ready`.
- Kernel stub with `fin` tied 0, TIMEOUT=16 → `kern_res` high for 2 cycles, `m_err`=1, `m_o`=0, `m_valid` 18 cycles after `req`. A following n=5 with the real kernel → 5.
- Stub pulses `fin` on the cycle the counter reaches TIMEOUT-1 → `m_err`=0, `m_o` equals the stub value, no recovery. Stray `fin` in IDLE → no output.
